// File: rtl/obufds_tx_pkg.sv
// Shared definitions for the LVDS serialising transmitter: FSM encoding,
// counter sizing and the level that starts the training pattern.
package obufds_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TRAIN = 2'd2
    } tx_state_e;

    localparam logic TRAIN_START_LEVEL = 1'b1;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width_v;
        width_v = 32'd1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                width_v = 32'(i) + 32'd1;
            end else begin
                width_v = width_v;
            end
        end
        return width_v;
    endfunction

endpackage

// File: rtl/obufds_tx_shift_reg.sv
// Load/shift register for the serialiser. load_bit is the first bit of the
// word on din; serial_bit is the next bit still waiting in the register.
module obufds_tx_shift_reg
    import obufds_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  load_bit,
    output logic                  serial_bit
);

    logic [DATA_WIDTH-1:0] sr_r;

    // Select the head bit of the incoming word and of the stored remainder.
    always_comb begin
        load_bit   = 1'b0;
        serial_bit = 1'b0;
        if (LSB_FIRST) begin
            load_bit   = din[0];
            serial_bit = sr_r[0];
        end else begin
            load_bit   = din[DATA_WIDTH-1];
            serial_bit = sr_r[DATA_WIDTH-1];
        end
    end

    // The head bit goes straight to the output register, so only the rest is stored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_r <= '0;
        end else if (load) begin
            if (LSB_FIRST) begin
                sr_r <= {1'b0, din[DATA_WIDTH-1:1]};
            end else begin
                sr_r <= {din[DATA_WIDTH-2:0], 1'b0};
            end
        end else if (shift) begin
            if (LSB_FIRST) begin
                sr_r <= {1'b0, sr_r[DATA_WIDTH-1:1]};
            end else begin
                sr_r <= {sr_r[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            sr_r <= sr_r;
        end
    end

endmodule

// File: rtl/obufds_lvdsext_25_tx.sv
// Serialising LVDS transmitter: parallel words in through valid/ready, one bit
// per clock out on the complementary pair O/OB, plus a training toggle pattern.
module obufds_lvdsext_25_tx
    import obufds_tx_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DVALID,
    output logic                  DREADY,
    input  logic                  TRAIN,
    output logic                  O,
    output logic                  OB,
    output logic                  FRAME,
    output logic                  BUSY
);

    localparam int CNT_W = clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             o_r;
    logic             ob_r;
    logic             frame_r;
    logic             busy_r;

    logic dready_s;
    logic load_s;
    logic shift_s;
    logic load_bit_s;
    logic serial_bit_s;

    // Handshake and shift-register control decoded from the current state.
    always_comb begin
        dready_s = 1'b0;
        load_s   = 1'b0;
        shift_s  = 1'b0;
        if (!RST_N) begin
            dready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            dready_s = 1'b1;
        end else if ((state_r == ST_SHIFT) && (cnt_r == LAST_CNT)) begin
            dready_s = 1'b1;
        end else if (state_r == ST_SHIFT) begin
            shift_s = 1'b1;
        end else begin
            dready_s = 1'b0;
        end
        load_s = dready_s & DVALID;
    end

    obufds_tx_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_shift_reg (
        .clk        (CLK),
        .rst_n      (RST_N),
        .load       (load_s),
        .shift      (shift_s),
        .din        (DIN),
        .load_bit   (load_bit_s),
        .serial_bit (serial_bit_s)
    );

    // Transmit FSM; O and OB are always written together so they never match.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            o_r     <= IDLE_LEVEL;
            ob_r    <= ~IDLE_LEVEL;
            frame_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (load_s) begin
                        state_r <= ST_SHIFT;
                        o_r     <= load_bit_s;
                        ob_r    <= ~load_bit_s;
                        frame_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else if (TRAIN) begin
                        state_r <= ST_TRAIN;
                        o_r     <= TRAIN_START_LEVEL;
                        ob_r    <= ~TRAIN_START_LEVEL;
                        frame_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        o_r     <= IDLE_LEVEL;
                        ob_r    <= ~IDLE_LEVEL;
                        frame_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r != LAST_CNT) begin
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        o_r     <= serial_bit_s;
                        ob_r    <= ~serial_bit_s;
                        frame_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else if (load_s) begin
                        // Back-to-back word: first bit follows the last with no gap.
                        cnt_r   <= '0;
                        o_r     <= load_bit_s;
                        ob_r    <= ~load_bit_s;
                        frame_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                        o_r     <= IDLE_LEVEL;
                        ob_r    <= ~IDLE_LEVEL;
                        frame_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_TRAIN: begin
                    cnt_r   <= '0;
                    frame_r <= 1'b0;
                    if (TRAIN) begin
                        o_r    <= ~o_r;
                        ob_r   <= o_r;
                        busy_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        o_r     <= IDLE_LEVEL;
                        ob_r    <= ~IDLE_LEVEL;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    o_r     <= IDLE_LEVEL;
                    ob_r    <= ~IDLE_LEVEL;
                    frame_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign DREADY = dready_s;
    assign O      = o_r;
    assign OB     = ob_r;
    assign FRAME  = frame_r;
    assign BUSY   = busy_r;

endmodule
